// File: rtl/mem_access_stage.sv
// Data-memory access stage sitting between EX/MEM and MEM/WB.
// Runs a req/ack transaction on the data port and stalls the pipeline until
// it completes (or times out). Formats sub-word stores and aligns and extends
// loads. Flags misaligned accesses, which are not issued.
//
// Data-port handshake: memReq stays high from the IDLE cycle that accepts an
// aligned op until memAck is seen (or the wait budget runs out). memAddr,
// memWe, memByteEn and memWdata are held stable for that whole window,
// because stall freezes the inputs. memAck counts only while memReq is high,
// and memRdata is sampled in the same cycle as memAck.
module mem_access_stage #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [1:0]  memSizeIn,
  input  logic        memUnsignedIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] writeDataIn,
  input  logic [1:0]  wbIn,
  input  logic [4:0]  registerRdIn,
  output logic [1:0]  wbOut,
  output logic [31:0] readDataOut,
  output logic [31:0] resultOut,
  output logic [4:0]  registerRdOut,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam bit             TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t           state, state_nxt;
  logic [31:0]      dataLatch, data_nxt;
  logic             errLatch, err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        mem_op;
  logic        is_byte, is_half, is_word;
  logic        mis;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] latch_val;

  assign mem_op  = memReadIn | memWriteIn;
  assign is_byte = (memSizeIn == 2'b00);
  assign is_half = (memSizeIn == 2'b01);
  assign is_word = memSizeIn[1];
  assign mis     = (is_half & addressIn[0]) | (is_word & (addressIn[1:0] != 2'b00));

  assign resultOut     = addressIn;
  assign registerRdOut = registerRdIn;
  assign memAddr       = {addressIn[31:2], 2'b00};
  assign memWe         = memWriteIn;

  // Store lane enables and replicated write data
  always_comb begin
    memByteEn = 4'b1111;
    memWdata  = writeDataIn;
    if (is_byte) begin
      memByteEn = 4'b0001 << addressIn[1:0];
      memWdata  = {4{writeDataIn[7:0]}};
    end else if (is_half) begin
      memByteEn = addressIn[1] ? 4'b1100 : 4'b0011;
      memWdata  = {2{writeDataIn[15:0]}};
    end
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    lane_byte = memRdata[7:0];
    case (addressIn[1:0])
      2'd0: lane_byte = memRdata[7:0];
      2'd1: lane_byte = memRdata[15:8];
      2'd2: lane_byte = memRdata[23:16];
      2'd3: lane_byte = memRdata[31:24];
      default: lane_byte = memRdata[7:0];
    endcase
    lane_half = addressIn[1] ? memRdata[31:16] : memRdata[15:0];
    if (is_byte)
      load_data = {{24{lane_byte[7] & ~memUnsignedIn}}, lane_byte};
    else if (is_half)
      load_data = {{16{lane_half[15] & ~memUnsignedIn}}, lane_half};
    else
      load_data = memRdata;
  end

  // Stores latch zero so that readDataOut reads 0 in DONE
  assign latch_val = memReadIn ? load_data : 32'd0;

  // Next-state, latch updates and stage outputs
  always_comb begin
    state_nxt   = state;
    data_nxt    = dataLatch;
    err_nxt     = errLatch;
    cnt_nxt     = cnt;
    memReq      = 1'b0;
    stall       = 1'b0;
    misaligned  = 1'b0;
    busError    = 1'b0;
    readDataOut = 32'd0;
    wbOut       = wbIn;
    case (state)
      S_IDLE: begin
        // rst gates the request so that it drops the moment reset asserts
        if (mem_op && !rst) begin
          if (mis) begin
            misaligned = 1'b1;
            wbOut      = 2'b00;
          end else begin
            memReq  = 1'b1;
            stall   = 1'b1;
            cnt_nxt = '0;
            if (memAck) begin
              data_nxt  = latch_val;
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        memReq  = 1'b1;
        stall   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (memAck) begin
          data_nxt  = latch_val;
          state_nxt = S_DONE;
        end else if (TIMEOUT_EN && (cnt == LAST_CNT)) begin
          err_nxt   = 1'b1;
          data_nxt  = 32'd0;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        readDataOut = dataLatch;
        busError    = errLatch;
        wbOut       = errLatch ? 2'b00 : wbIn;
        err_nxt     = 1'b0;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dataLatch <= 32'd0;
      errLatch  <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      dataLatch <= data_nxt;
      errLatch  <= err_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (MAX_WAIT = 4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadIn, memWriteIn, memUnsignedIn;
  logic [1:0]  memSizeIn;
  logic [31:0] addressIn, writeDataIn;
  logic [1:0]  wbIn;
  logic [4:0]  registerRdIn;
  logic [1:0]  wbOut;
  logic [31:0] readDataOut, resultOut;
  logic [4:0]  registerRdOut;
  logic        stall, misaligned, busError, memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRdata;

  int total = 0;
  int bad   = 0;

  // Values observed by do_op
  int          stall_cnt;
  logic        req_seen, we_seen, mis_seen;
  logic [31:0] addr_seen, wd_seen;
  logic [3:0]  be_seen;
  logic [31:0] done_rdata, done_result;
  logic [1:0]  done_wb;
  logic [4:0]  done_rd;
  logic        done_err, done_req, done_stall;

  mem_access_stage #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .memSizeIn(memSizeIn),
    .memUnsignedIn(memUnsignedIn), .addressIn(addressIn), .writeDataIn(writeDataIn),
    .wbIn(wbIn), .registerRdIn(registerRdIn),
    .wbOut(wbOut), .readDataOut(readDataOut), .resultOut(resultOut),
    .registerRdOut(registerRdOut), .stall(stall), .misaligned(misaligned),
    .busError(busError), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memByteEn(memByteEn), .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    memReadIn = 0; memWriteIn = 0; memSizeIn = 2'b10; memUnsignedIn = 0;
    writeDataIn = 0; memAck = 0; memRdata = 0;
  endtask

  // Applies one op in IDLE right after a clock edge. ack_wait: 0 = ack in the
  // request cycle, n > 0 = ack during the n-th WAIT cycle, -1 = never.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] wb, input logic [4:0] rdreg,
                       input int ack_wait, input logic [31:0] rdata);
    memReadIn = rd; memWriteIn = wr; memSizeIn = size; memUnsignedIn = uns;
    addressIn = addr; writeDataIn = wdata; wbIn = wb; registerRdIn = rdreg;
    memRdata = rdata;
    memAck = (ack_wait == 0);
    #1;
    req_seen = memReq; we_seen = memWe; mis_seen = misaligned;
    addr_seen = memAddr; be_seen = memByteEn; wd_seen = memWdata;
    stall_cnt = 0;
    while (stall && stall_cnt < 20) begin
      stall_cnt++;
      @(posedge clk); #1;
      memAck = (stall_cnt == ack_wait);
      #1;
    end
    memAck = 0;
    #1;
    done_rdata = readDataOut; done_result = resultOut; done_wb = wbOut;
    done_rd = registerRdOut; done_err = busError; done_req = memReq;
    done_stall = stall;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    // Reset state
    rst = 1; clear_inputs(); addressIn = 0; wbIn = 0; registerRdIn = 0;
    #1;
    chk("rst_req", {31'd0, memReq}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", readDataOut, 32'd0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // lw 0x100, ack in the third WAIT cycle
    do_op(1, 0, 2'b10, 0, 32'h100, 0, 2'b11, 5'd5, 3, 32'hDEADBEEF);
    chk("lw_addr", addr_seen, 32'h100);
    chk("lw_be", {28'd0, be_seen}, 32'hF);
    chk("lw_we", {31'd0, we_seen}, 32'd0);
    chk("lw_stall_cnt", stall_cnt, 4);
    chk("lw_rdata", done_rdata, 32'hDEADBEEF);
    chk("lw_wb", {30'd0, done_wb}, 32'd3);
    chk("lw_rd", {27'd0, done_rd}, 32'd5);
    chk("lw_done_req", {31'd0, done_req}, 32'd0);

    // lb signed / lbu at 0x103, same-cycle ack on the first
    do_op(1, 0, 2'b00, 0, 32'h103, 0, 2'b11, 5'd6, 0, 32'h80FF1234);
    chk("lb_stall_cnt", stall_cnt, 1);
    chk("lb_rdata", done_rdata, 32'hFFFFFF80);
    do_op(1, 0, 2'b00, 1, 32'h103, 0, 2'b11, 5'd6, 1, 32'h80FF1234);
    chk("lbu_rdata", done_rdata, 32'h00000080);
    do_op(1, 0, 2'b01, 1, 32'h102, 0, 2'b11, 5'd6, 2, 32'h80FF1234);
    chk("lhu_rdata", done_rdata, 32'h000080FF);
    do_op(1, 0, 2'b01, 0, 32'h102, 0, 2'b11, 5'd6, 1, 32'h80FF1234);
    chk("lh_rdata", done_rdata, 32'hFFFF80FF);
    do_op(1, 0, 2'b00, 0, 32'h101, 0, 2'b11, 5'd6, 1, 32'h80FF1234);
    chk("lb1_rdata", done_rdata, 32'h00000012);

    // Stores
    do_op(0, 1, 2'b00, 0, 32'h201, 32'h000000AB, 2'b00, 5'd0, 1, 32'hFFFFFFFF);
    chk("sb_we", {31'd0, we_seen}, 32'd1);
    chk("sb_req", {31'd0, req_seen}, 32'd1);
    chk("sb_addr", addr_seen, 32'h200);
    chk("sb_be", {28'd0, be_seen}, 32'h2);
    chk("sb_wd", wd_seen, 32'hABABABAB);
    chk("sb_rdata", done_rdata, 32'd0);
    do_op(0, 1, 2'b01, 0, 32'h202, 32'h00001234, 2'b00, 5'd0, 1, 0);
    chk("sh_be", {28'd0, be_seen}, 32'hC);
    chk("sh_wd", wd_seen, 32'h12341234);
    do_op(0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 2'b00, 5'd0, 1, 0);
    chk("sw_be", {28'd0, be_seen}, 32'hF);
    chk("sw_wd", wd_seen, 32'hCAFEF00D);

    // Misaligned lw: no request, no stall, write-back suppressed
    do_op(1, 0, 2'b10, 0, 32'h102, 0, 2'b11, 5'd9, -1, 0);
    chk("mis_req", {31'd0, req_seen}, 32'd0);
    chk("mis_flag", {31'd0, mis_seen}, 32'd1);
    chk("mis_stall_cnt", stall_cnt, 0);
    chk("mis_wb", {30'd0, done_wb}, 32'd0);
    chk("mis_rdata", done_rdata, 32'd0);

    // Non-memory op passes straight through
    do_op(0, 0, 2'b10, 0, 32'h12345678, 0, 2'b10, 5'd7, -1, 0);
    chk("alu_stall_cnt", stall_cnt, 0);
    chk("alu_wb", {30'd0, done_wb}, 32'd2);
    chk("alu_result", done_result, 32'h12345678);
    chk("alu_rd", {27'd0, done_rd}, 32'd7);
    chk("alu_req", {31'd0, req_seen}, 32'd0);

    // Timeout with MAX_WAIT=4 and no ack
    do_op(1, 0, 2'b10, 0, 32'h300, 0, 2'b11, 5'd3, -1, 0);
    chk("to_stall_cnt", stall_cnt, 5);
    chk("to_buserr", {31'd0, done_err}, 32'd1);
    chk("to_wb", {30'd0, done_wb}, 32'd0);
    chk("to_req", {31'd0, done_req}, 32'd0);
    chk("to_rdata", done_rdata, 32'd0);
    do_op(1, 0, 2'b10, 0, 32'h304, 0, 2'b11, 5'd3, 1, 32'h01020304);
    chk("after_to_rdata", done_rdata, 32'h01020304);
    chk("after_to_buserr", {31'd0, done_err}, 32'd0);
    chk("after_to_wb", {30'd0, done_wb}, 32'd3);

    // Asynchronous reset in the middle of WAIT
    memReadIn = 1; memSizeIn = 2'b10; addressIn = 32'h400; wbIn = 2'b11; registerRdIn = 5'd4;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1; #1;
    chk("arst_req", {31'd0, memReq}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_rdata", readDataOut, 32'd0);
    clear_inputs(); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("arst_idle_stall", {31'd0, stall}, 32'd0);
    do_op(1, 0, 2'b10, 0, 32'h400, 0, 2'b11, 5'd4, 2, 32'h55AA55AA);
    chk("arst_lw_stall_cnt", stall_cnt, 3);
    chk("arst_lw_rdata", done_rdata, 32'h55AA55AA);
    chk("arst_lw_wb", {30'd0, done_wb}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
